// File: rtl/fire_arbiter_if.sv
// Bundle of fire requests, gating qualifiers and launch/ready results for fire_arbiter.
// Latency: none, wires only.
// Backpressure: none; busy/shield inputs gate grants inside the arbiter.
interface fire_arbiter_if;
  logic i_enable;
  logic i_frame_tick;
  logic i_player_fire;
  logic i_enemy_fire;
  logic i_player_busy;
  logic i_enemy_busy;
  logic i_player_shield;
  logic i_enemy_shield;
  logic o_player_launch;
  logic o_enemy_launch;
  logic o_player_ready;
  logic o_enemy_ready;
  logic o_last_grant;

  // Source side: game logic driving requests and observing launches
  modport master (
    output i_enable, i_frame_tick, i_player_fire, i_enemy_fire,
    output i_player_busy, i_enemy_busy, i_player_shield, i_enemy_shield,
    input  o_player_launch, o_enemy_launch, o_player_ready, o_enemy_ready, o_last_grant
  );

  // Arbiter side
  modport slave (
    input  i_enable, i_frame_tick, i_player_fire, i_enemy_fire,
    input  i_player_busy, i_enemy_busy, i_player_shield, i_enemy_shield,
    output o_player_launch, o_enemy_launch, o_player_ready, o_enemy_ready, o_last_grant
  );
endinterface

// File: rtl/fire_arbiter.sv
// Sequences player/enemy bullet launches onto one spawn slot, at most one per frame tick.
// Latency: grant on tick cycle N, launch pulse in cycle N+1.
// Backpressure: busy/shield hold a pending request; requests arriving while not idle are dropped.
module fire_arbiter #(
  parameter int COOLDOWN = 4,
  parameter int CW       = ((COOLDOWN + 1) <= 1) ? 1 : $clog2(COOLDOWN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  fire_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PEND, LAUNCH, COOL} state_t;

  // Index 0 is the player, index 1 the enemy.
  state_t          state_q [2];
  state_t          state_d [2];
  logic [CW-1:0]   cnt_q   [2];
  logic [CW-1:0]   cnt_d   [2];
  logic [1:0]      fire;
  logic [1:0]      fire_q;
  logic [1:0]      busy;
  logic [1:0]      shield;
  logic [1:0]      elig;
  logic [1:0]      grant;
  logic            last_q;
  logic            last_d;

  assign fire   = {bus.i_enemy_fire,   bus.i_player_fire};
  assign busy   = {bus.i_enemy_busy,   bus.i_player_busy};
  assign shield = {bus.i_enemy_shield, bus.i_player_shield};

  // Pick at most one eligible requester per enabled tick; ties go to the side that lost last time
  always_comb begin
    grant = 2'b00;
    for (int i = 0; i < 2; i++) begin
      elig[i] = (state_q[i] == PEND) && !busy[i] && !shield[i];
    end
    if (bus.i_frame_tick && bus.i_enable) begin
      if (elig[0] && (!elig[1] || last_q)) begin
        grant[0] = 1'b1;
      end else if (elig[1]) begin
        grant[1] = 1'b1;
      end
    end
  end

  // Per-requester next state: edge-latched request, launch, frame-counted cooldown; disable flushes
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (!bus.i_enable) begin
        state_d[i] = IDLE;
        cnt_d[i]   = '0;
      end else begin
        case (state_q[i])
          IDLE: begin
            if (fire[i] && !fire_q[i]) state_d[i] = PEND;
          end
          PEND: begin
            if (grant[i]) state_d[i] = LAUNCH;
          end
          LAUNCH: begin
            if (COOLDOWN == 0) begin
              state_d[i] = IDLE;
            end else begin
              state_d[i] = COOL;
              cnt_d[i]   = CW'(COOLDOWN);
            end
          end
          COOL: begin
            // Counter stops at zero rather than wrapping
            if (bus.i_frame_tick) begin
              if (cnt_q[i] > CW'(1)) begin
                cnt_d[i] = cnt_q[i] - CW'(1);
              end else begin
                cnt_d[i]   = '0;
                state_d[i] = IDLE;
              end
            end
          end
          default: begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end
        endcase
      end
    end
  end

  // Remember who won; a flush restores player priority for the next tie
  always_comb begin
    last_d = last_q;
    if (!bus.i_enable) begin
      last_d = 1'b1;
    end else if (grant[0]) begin
      last_d = 1'b0;
    end else if (grant[1]) begin
      last_d = 1'b1;
    end
  end

  // State registers; fire_q keeps tracking through a flush so held buttons never re-fire
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      fire_q <= 2'b00;
      last_q <= 1'b1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      fire_q <= fire;
      last_q <= last_d;
    end
  end

  assign bus.o_player_launch = (state_q[0] == LAUNCH);
  assign bus.o_enemy_launch  = (state_q[1] == LAUNCH);
  assign bus.o_player_ready  = (state_q[0] == IDLE) && !bus.i_player_busy;
  assign bus.o_enemy_ready   = (state_q[1] == IDLE) && !bus.i_enemy_busy;
  assign bus.o_last_grant    = last_q;

endmodule

// File: tb/tb_fire_arbiter.sv
// Directed bench for fire_arbiter with COOLDOWN=4 and COOLDOWN=0 instances.
// Latency: inputs set just after a rising edge are sampled at the next one.
// Backpressure: busy/shield driven directly by the stimulus.
module tb_fire_arbiter;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   launches;

  fire_arbiter_if ifc4 ();
  fire_arbiter_if ifc0 ();

  fire_arbiter #(.COOLDOWN(4)) dut4 (.clk(clk), .rst(rst), .bus(ifc4));
  fire_arbiter #(.COOLDOWN(0)) dut0 (.clk(clk), .rst(rst), .bus(ifc0));

  // 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance into the next cycle, away from the clock edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One-cycle frame tick on the COOLDOWN=4 instance; returns in the cycle a launch would show
  task automatic tick4();
    ifc4.i_frame_tick = 1'b1;
    cyc();
    ifc4.i_frame_tick = 1'b0;
  endtask

  task automatic tick0();
    ifc0.i_frame_tick = 1'b1;
    cyc();
    ifc0.i_frame_tick = 1'b0;
  endtask

  // Let any pending request launch and any cooldown expire
  task automatic drain4();
    repeat (7) begin
      tick4();
      cyc();
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    launches = 0;
    rst = 1'b1;
    ifc4.i_enable = 1'b1; ifc4.i_frame_tick = 1'b0;
    ifc4.i_player_fire = 1'b0; ifc4.i_enemy_fire = 1'b0;
    ifc4.i_player_busy = 1'b0; ifc4.i_enemy_busy = 1'b0;
    ifc4.i_player_shield = 1'b0; ifc4.i_enemy_shield = 1'b0;
    ifc0.i_enable = 1'b1; ifc0.i_frame_tick = 1'b0;
    ifc0.i_player_fire = 1'b0; ifc0.i_enemy_fire = 1'b0;
    ifc0.i_player_busy = 1'b0; ifc0.i_enemy_busy = 1'b0;
    ifc0.i_player_shield = 1'b0; ifc0.i_enemy_shield = 1'b0;

    // Reset state
    #12;
    check("rst_p_launch", ifc4.o_player_launch, 0);
    check("rst_e_launch", ifc4.o_enemy_launch, 0);
    check("rst_p_ready", ifc4.o_player_ready, 1);
    check("rst_e_ready", ifc4.o_enemy_ready, 1);
    check("rst_last", ifc4.o_last_grant, 1);
    @(negedge clk) rst = 1'b0;
    cyc();

    // Single player request: PEND next cycle, launch the cycle after the tick, 4-tick cooldown
    ifc4.i_player_fire = 1'b1;
    cyc();
    check("t1_pend_ready", ifc4.o_player_ready, 0);
    check("t1_pend_launch", ifc4.o_player_launch, 0);
    cyc();
    check("t1_pre_tick", ifc4.o_player_launch, 0);
    tick4();
    check("t1_launch", ifc4.o_player_launch, 1);
    check("t1_e_launch", ifc4.o_enemy_launch, 0);
    check("t1_last", ifc4.o_last_grant, 0);
    cyc();
    check("t1_one_pulse", ifc4.o_player_launch, 0);
    repeat (3) begin
      tick4();
      cyc();
    end
    check("t1_cool3_ready", ifc4.o_player_ready, 0);
    tick4();
    check("t1_cool4_ready", ifc4.o_player_ready, 1);
    ifc4.i_player_fire = 1'b0;
    cyc();

    // Flush restores player priority
    ifc4.i_enable = 1'b0;
    cyc();
    ifc4.i_enable = 1'b1;
    check("t2_flush_last", ifc4.o_last_grant, 1);

    // Tie: player first, enemy next tick, then player again on a fresh tie
    ifc4.i_player_fire = 1'b1;
    ifc4.i_enemy_fire = 1'b1;
    cyc();
    tick4();
    check("t2_tie1_p", ifc4.o_player_launch, 1);
    check("t2_tie1_e", ifc4.o_enemy_launch, 0);
    check("t2_tie1_last", ifc4.o_last_grant, 0);
    check("t2_tie1_e_pend", ifc4.o_enemy_ready, 0);
    cyc();
    tick4();
    check("t2_tie2_e", ifc4.o_enemy_launch, 1);
    check("t2_tie2_p", ifc4.o_player_launch, 0);
    check("t2_tie2_last", ifc4.o_last_grant, 1);
    ifc4.i_player_fire = 1'b0;
    ifc4.i_enemy_fire = 1'b0;
    repeat (5) begin
      cyc();
      tick4();
    end
    cyc();
    ifc4.i_player_fire = 1'b1;
    ifc4.i_enemy_fire = 1'b1;
    cyc();
    tick4();
    check("t2_tie3_p", ifc4.o_player_launch, 1);
    check("t2_tie3_e", ifc4.o_enemy_launch, 0);
    check("t2_tie3_last", ifc4.o_last_grant, 0);
    ifc4.i_player_fire = 1'b0;
    ifc4.i_enemy_fire = 1'b0;
    drain4();

    // Busy holds a pending player request until it clears
    ifc4.i_player_busy = 1'b1;
    ifc4.i_player_fire = 1'b1;
    cyc();
    for (int k = 0; k < 3; k++) begin
      tick4();
      check("t3_busy_no_launch", ifc4.o_player_launch, 0);
    end
    ifc4.i_player_busy = 1'b0;
    cyc();
    check("t3_pend_kept", ifc4.o_player_ready, 0);
    tick4();
    check("t3_launch", ifc4.o_player_launch, 1);
    ifc4.i_player_fire = 1'b0;
    drain4();

    // Held fire plus a re-press during cooldown yields exactly one launch
    for (int i = 0; i < 50; i++) begin
      ifc4.i_player_fire = (i != 15);
      ifc4.i_frame_tick = ((i % 5) == 4);
      cyc();
      if (ifc4.o_player_launch) launches++;
    end
    ifc4.i_frame_tick = 1'b0;
    check("t4_launch_count", launches, 1);
    ifc4.i_player_fire = 1'b0;
    cyc();

    // Shielded enemy request is flushed by a one-cycle disable
    ifc4.i_enemy_shield = 1'b1;
    ifc4.i_enemy_fire = 1'b1;
    cyc();
    check("t5_pend", ifc4.o_enemy_ready, 0);
    tick4();
    check("t5_shield_no_launch", ifc4.o_enemy_launch, 0);
    ifc4.i_enable = 1'b0;
    cyc();
    ifc4.i_enable = 1'b1;
    ifc4.i_enemy_shield = 1'b0;
    check("t5_flushed_idle", ifc4.o_enemy_ready, 1);
    check("t5_flush_last", ifc4.o_last_grant, 1);
    tick4();
    check("t5_no_launch", ifc4.o_enemy_launch, 0);
    cyc();
    check("t5_still_idle", ifc4.o_enemy_ready, 1);
    ifc4.i_enemy_fire = 1'b0;
    cyc();

    // COOLDOWN=0: back-to-back launches, straight back to IDLE
    ifc0.i_player_fire = 1'b1;
    cyc();
    tick0();
    check("t6_launch1", ifc0.o_player_launch, 1);
    ifc0.i_player_fire = 1'b0;
    cyc();
    check("t6_idle1", ifc0.o_player_ready, 1);
    ifc0.i_player_fire = 1'b1;
    cyc();
    tick0();
    check("t6_launch2", ifc0.o_player_launch, 1);
    cyc();
    check("t6_idle2", ifc0.o_player_ready, 1);
    check("t6_launch_end", ifc0.o_player_launch, 0);
    ifc0.i_player_fire = 1'b0;
    cyc();

    // Reset in the launch cycle kills the pulse immediately
    ifc4.i_player_fire = 1'b1;
    cyc();
    tick4();
    check("t7_launch", ifc4.o_player_launch, 1);
    rst = 1'b1;
    #1;
    check("t7_rst_drop", ifc4.o_player_launch, 0);
    ifc4.i_player_fire = 1'b0;
    @(negedge clk) rst = 1'b0;
    cyc();
    check("t7_p_ready", ifc4.o_player_ready, 1);
    check("t7_e_ready", ifc4.o_enemy_ready, 1);
    check("t7_last", ifc4.o_last_grant, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/fire_arbiter.md
Name: fire_arbiter

Overview:
- Sequences bullet launches for player and enemy onto the single shared bullet-spawn port. Only one spawn is allowed per frame tick.
- Sits between the input sources and the GoodBullet/BadBullet blocks:
  - player buttons feed player fire; the Random outputs feed enemy fire.
- Per-requester FSM handles edge-latched requests, busy/shield gating and a frame-counted cooldown.
- Ties on the same tick are resolved round-robin.

Parameters:
- COOLDOWN, 4, frame ticks a requester is blocked after a launch (0..255; 0 = no cooldown).
- CW, $clog2(COOLDOWN+1) (minimum 1), width of the cooldown counters.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_enable  in  1  high while game is in play state; low = flush.
- i_frame_tick  in  1  one-cycle pulse, once per video frame.
- i_player_fire  in  1  player attack level (button).
- i_enemy_fire  in  1  enemy attack level (random source).
- i_player_busy  in  1  player bullet currently in flight.
- i_enemy_busy  in  1  enemy bullet currently in flight.
- i_player_shield  in  1  player defending; cannot fire.
- i_enemy_shield  in  1  enemy defending; cannot fire.
- o_player_launch  out  1  one-cycle spawn pulse to player bullet.
- o_enemy_launch  out  1  one-cycle spawn pulse to enemy bullet.
- o_player_ready  out  1  player FSM in IDLE and ~i_player_busy.
- o_enemy_ready  out  1  enemy FSM in IDLE and ~i_enemy_busy.
- o_last_grant  out  1  0 = player won last grant, 1 = enemy.

Behaviour:
- Reset (async, rst=1):
  - both FSMs IDLE, counters 0, fire edge registers 0, o_last_grant=1 (player wins first tie).
  - all launch outputs 0; ready outputs follow their definition.
- Edge detect: fire_q registered each cycle. Request event = fire & ~fire_q.
  - A held level never re-requests.
- Per-requester FSM, states IDLE, PEND, LAUNCH, COOL:
  - IDLE -> PEND on request event (state visible next cycle). Event in any other state is dropped, not queued.
  - PEND holds until granted. Dropping the fire level does not cancel it.
  - Eligible = PEND & ~busy & ~shield.
  - PEND -> LAUNCH when granted. Grant only in a cycle with i_frame_tick=1 and i_enable=1.
  - LAUNCH lasts exactly one cycle; o_*_launch = (state==LAUNCH). Latency: tick cycle N grant -> launch high at N+1.
  - LAUNCH -> COOL with cnt=COOLDOWN, or -> IDLE directly if COOLDOWN=0.
  - COOL: on each i_frame_tick, cnt decrements. When cnt==1 and tick, cnt->0 and state->IDLE. No decrement without tick.
- Arbitration (tick cycle only), at most one grant per tick:
  - exactly one eligible: grant it.
  - both eligible: grant the side not equal to o_last_grant.
  - loser stays PEND and competes on the next tick.
  - o_last_grant updates only on a grant.
- Shield or busy asserted while PEND: request waits, no grant. Once both clear, eligible on the next tick.
- Shield/busy asserted during LAUNCH or COOL: no effect on sequencing.
- i_enable=0 (synchronous flush, highest priority after rst):
  - next cycle both FSMs IDLE, counters 0, o_last_grant=1.
  - no launch issued; a LAUNCH state present at the flush cycle still completes its current-cycle pulse.
  - fire_q keeps tracking, so a button held across enable does not fire.
- Reset mid-LAUNCH: pulse drops immediately (asynchronous).
- Counter is CW bits and never wraps: decrement only when cnt>0.

Test Plan:
- COOLDOWN=4: player fire rises at cycle 10, tick at 12.
  - -> player PEND at 11; o_player_launch high only at 13; o_last_grant=0.
  - ready returns after 4 further ticks.
- Both fire rise together, ticks T1,T2 after reset:
  - -> T1+1 player launch, T2+1 enemy launch, o_last_grant 0 then 1.
  - a third simultaneous tie next grants player.
- Player PEND with i_player_busy=1 for 3 ticks, then busy=0:
  - -> no launch during busy; launch one cycle after the first tick with busy=0.
- Player holds fire high 50 cycles through cooldown -> exactly one launch; a second rising edge during COOL -> still one launch.
- Enemy PEND with shield=1, i_enable dropped for one cycle, then shield released -> no launch (request flushed), FSM IDLE, o_last_grant=1.
- COOLDOWN=0: player edges before consecutive ticks -> launch after each tick; no COOL state visited.
- rst asserted in the LAUNCH cycle -> o_player_launch falls the same cycle; FSMs IDLE after release.
